// File: rtl/tri_assign_pkg.sv
// Shared constants for the tri_assign training block: default operand width
// and the depth of each registered path, so benches and docs agree with the RTL.
package tri_assign_pkg;

  // Default operand width used by the training benches.
  localparam int unsigned TRI_WIDTH_DEFAULT = 32'd1;

  // Register stages on each output path (c1 is purely combinational).
  localparam int unsigned TRI_C1_STAGES = 32'd0;
  localparam int unsigned TRI_C2_STAGES = 32'd1;
  localparam int unsigned TRI_C3_STAGES = 32'd2;

endpackage : tri_assign_pkg

// File: rtl/tri_assign_dff_ar.sv
// Parameterised D flip-flop with asynchronous active-low clear.
// Used as the building block for every registered stage of tri_assign.
module tri_assign_dff_ar #(
  parameter int unsigned WIDTH = 32'd1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  // Capture the input on every rising edge; clear at once when reset drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule : tri_assign_dff_ar

// File: rtl/tri_assign.sv
// tri_assign: the same bitwise a & b function presented three ways.
//   c1 - combinational, follows the inputs with no storage, ignores reset
//   c2 - one register stage (temporary t2 = a & b captured at the edge)
//   c3 - two register stages (s3 captures a & b, c3 captures s3)
// Temporaries are internal only; reset clears every stored stage at once.
module tri_assign
  import tri_assign_pkg::*;
#(
  parameter int unsigned WIDTH = TRI_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c1,
  output logic [WIDTH-1:0] c2,
  output logic [WIDTH-1:0] c3
);

  // Shared product of the operands; each path decides how much storage it adds.
  logic [WIDTH-1:0] w_and;
  // c2 temporary: computed and consumed within the same edge, so it adds no stage.
  logic [WIDTH-1:0] w_t2;
  // c3 chain: first and second stage outputs.
  logic [WIDTH-1:0] w_s3;
  logic [WIDTH-1:0] w_c2_q;
  logic [WIDTH-1:0] w_c3_q;

  assign w_and = a & b;

  // c1: continuous assignment, no storage, unaffected by reset.
  assign c1 = w_and;

  // c2: the temporary is resolved before the edge, so one flop captures it.
  assign w_t2 = w_and;

  tri_assign_dff_ar #(.WIDTH(WIDTH)) u_c2_stage (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (w_t2),
    .o_q   (w_c2_q)
  );

  // c3: s3 holds the value sampled this edge, c3 the value from the edge before.
  tri_assign_dff_ar #(.WIDTH(WIDTH)) u_s3_stage (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (w_and),
    .o_q   (w_s3)
  );

  tri_assign_dff_ar #(.WIDTH(WIDTH)) u_c3_stage (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (w_s3),
    .o_q   (w_c3_q)
  );

  assign c2 = w_c2_q;
  assign c3 = w_c3_q;

endmodule : tri_assign

// File: tb/tb_tri_assign.sv
// Bench for tri_assign: directed reset / latency / pulse / glitch / async-reset
// scenarios on a WIDTH=1 instance, plus a randomised regression driving a
// WIDTH=1 and a WIDTH=8 instance against a queue of expected products.
module tb_tri_assign;

  logic       clk;
  logic       rst_n;
  logic [0:0] a1, b1;
  logic [0:0] c1_1, c2_1, c3_1;
  logic [7:0] a8, b8;
  logic [7:0] c1_8, c2_8, c3_8;

  int n_checks = 0;
  int n_errors = 0;

  logic [0:0] q1[$];
  logic [7:0] q8[$];

  tri_assign #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1),
    .c1(c1_1), .c2(c2_1), .c3(c3_1)
  );

  tri_assign #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8),
    .c1(c1_8), .c2(c2_8), .c3(c3_8)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0; a1 = 1'b1; b1 = 1'b1; a8 = 8'hF0; b8 = 8'h3C;
    #3;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (c1_1 !== 1'b1 || c2_1 !== 1'b0 || c3_1 !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_hold_w1 edge %0d: c1=%b c2=%b c3=%b, want c1=1 c2=0 c3=0", i, c1_1, c2_1, c3_1);
      end
      n_checks++;
      if (c1_8 !== 8'h30 || c2_8 !== 8'h00 || c3_8 !== 8'h00) begin
        n_errors++;
        $display("FAIL reset_hold_w8 edge %0d: c1=%h c2=%h c3=%h, want c1=30 c2=00 c3=00", i, c1_8, c2_8, c3_8);
      end
    end
  endtask

  task automatic test_release();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (c2_1 !== 1'b1 || c3_1 !== 1'b0) begin
      n_errors++;
      $display("FAIL release_edge0_w1: c2=%b c3=%b, want c2=1 c3=0", c2_1, c3_1);
    end
    n_checks++;
    if (c2_8 !== 8'h30 || c3_8 !== 8'h00) begin
      n_errors++;
      $display("FAIL release_edge0_w8: c2=%h c3=%h, want c2=30 c3=00", c2_8, c3_8);
    end
    @(posedge clk); #1;
    n_checks++;
    if (c2_1 !== 1'b1 || c3_1 !== 1'b1) begin
      n_errors++;
      $display("FAIL release_edge1_w1: c2=%b c3=%b, want c2=1 c3=1", c2_1, c3_1);
    end
    n_checks++;
    if (c3_8 !== 8'h30) begin
      n_errors++;
      $display("FAIL release_edge1_w8: c3=%h, want 30", c3_8);
    end
  endtask

  task automatic test_pulse();
    logic [0:0] exp_c2[4];
    logic [0:0] exp_c3[4];
    exp_c2[0] = 1'b1; exp_c3[0] = 1'b0;
    exp_c2[1] = 1'b0; exp_c3[1] = 1'b1;
    exp_c2[2] = 1'b0; exp_c3[2] = 1'b0;
    exp_c2[3] = 1'b0; exp_c3[3] = 1'b0;
    @(negedge clk);
    a1 = 1'b0; b1 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (c2_1 !== 1'b0 || c3_1 !== 1'b0) begin
      n_errors++;
      $display("FAIL pulse_idle: c2=%b c3=%b, want 0 0", c2_1, c3_1);
    end
    @(negedge clk);
    a1 = 1'b1;
    #1;
    n_checks++;
    if (c1_1 !== 1'b1) begin
      n_errors++;
      $display("FAIL pulse_c1_high: c1=%b, want 1", c1_1);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (c2_1 !== exp_c2[i] || c3_1 !== exp_c3[i]) begin
        n_errors++;
        $display("FAIL pulse_edge%0d: c2=%b c3=%b, want c2=%b c3=%b", i, c2_1, c3_1, exp_c2[i], exp_c3[i]);
      end
      if (i == 0) begin
        @(negedge clk);
        a1 = 1'b0;
        #1;
        n_checks++;
        if (c1_1 !== 1'b0) begin
          n_errors++;
          $display("FAIL pulse_c1_low: c1=%b, want 0", c1_1);
        end
      end
    end
  endtask

  task automatic test_glitch();
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b1;
    repeat (2) @(posedge clk);
    #5;
    a1 = 1'b0;
    #1;
    n_checks++;
    if (c1_1 !== 1'b0 || c2_1 !== 1'b1 || c3_1 !== 1'b1) begin
      n_errors++;
      $display("FAIL glitch_low: c1=%b c2=%b c3=%b, want c1=0 c2=1 c3=1", c1_1, c2_1, c3_1);
    end
    #2;
    a1 = 1'b1;
    #1;
    n_checks++;
    if (c1_1 !== 1'b1) begin
      n_errors++;
      $display("FAIL glitch_recover: c1=%b, want 1", c1_1);
    end
    @(posedge clk); #1;
    n_checks++;
    if (c2_1 !== 1'b1 || c3_1 !== 1'b1) begin
      n_errors++;
      $display("FAIL glitch_after_edge: c2=%b c3=%b, want 1 1", c2_1, c3_1);
    end
  endtask

  task automatic test_async_reset();
    @(posedge clk);
    #5;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (c1_1 !== 1'b1 || c2_1 !== 1'b0 || c3_1 !== 1'b0) begin
      n_errors++;
      $display("FAIL async_reset_w1: c1=%b c2=%b c3=%b, want c1=1 c2=0 c3=0", c1_1, c2_1, c3_1);
    end
    n_checks++;
    if (c2_8 !== 8'h00 || c3_8 !== 8'h00) begin
      n_errors++;
      $display("FAIL async_reset_w8: c2=%h c3=%h, want 00 00", c2_8, c3_8);
    end
  endtask

  task automatic test_random();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    q1.delete(); q8.delete();
    q1.push_back(1'b0); q8.push_back(8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    a1 = 1'($urandom_range(0, 1)); b1 = 1'($urandom_range(0, 1));
    a8 = 8'($urandom); b8 = 8'($urandom);
    q1.push_back(a1 & b1); q8.push_back(a8 & b8);
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (c2_1 !== q1[1] || c3_1 !== q1[0]) begin
        n_errors++;
        $display("FAIL random_w1 cyc %0d: c2=%b c3=%b, want c2=%b c3=%b", i, c2_1, c3_1, q1[1], q1[0]);
      end
      n_checks++;
      if (c2_8 !== q8[1] || c3_8 !== q8[0]) begin
        n_errors++;
        $display("FAIL random_w8 cyc %0d: c2=%h c3=%h, want c2=%h c3=%h", i, c2_8, c3_8, q8[1], q8[0]);
      end
      void'(q1.pop_front()); void'(q8.pop_front());
      #2;
      a1 = 1'($urandom_range(0, 1)); a8 = 8'($urandom);
      #4;
      b1 = 1'($urandom_range(0, 1)); b8 = 8'($urandom);
      #2;
      n_checks++;
      if (c1_1 !== (a1 & b1) || c1_8 !== (a8 & b8)) begin
        n_errors++;
        $display("FAIL random_c1 cyc %0d: c1_1=%b c1_8=%h, want %b %h", i, c1_1, c1_8, a1 & b1, a8 & b8);
      end
      q1.push_back(a1 & b1); q8.push_back(a8 & b8);
    end
  endtask

  initial begin
    test_reset();
    test_release();
    test_pulse();
    test_glitch();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_tri_assign
